axi_lite_mem_slave: RTL
=======================

AXI_LITE_MEM_SLAVE -- requirements
Module: axi_lite_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values 8, 16, 32, 64; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter MEM_BYTES, default 4096, memory size in bytes; power of two, at least STRB_WIDTH.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of memory byte 0; aligned to MEM_BYTES.
REQ-005 SHALL have ports ACLK in 1 (the single clock) and ARESETN in 1 (reset, asynchronous, active-low).
REQ-006 SHALL have write-address ports: AWADDR in ADDR_WIDTH; AWVALID in 1; AWREADY out 1.
REQ-007 SHALL have write-data ports: WDATA in DATA_WIDTH; WSTRB in STRB_WIDTH (byte enables); WVALID in 1; WREADY out 1.
REQ-008 SHALL have write-response ports: BRESP out 2; BVALID out 1; BREADY in 1.
REQ-009 SHALL have read-address ports: ARADDR in ADDR_WIDTH; ARVALID in 1; ARREADY out 1.
REQ-010 SHALL have read-data ports: RDATA out DATA_WIDTH; RRESP out 2; RVALID out 1; RREADY in 1.

Function
REQ-011 SHALL run the write and read paths as independent FSMs, so one write and one read may be in flight concurrently.
REQ-012 SHALL use write FSM states IDLE, WADDR, WDATA, WRESP.
- IDLE: AWREADY=WREADY=1.
- AW alone handshakes -> WDATA (AWREADY=0).
- W alone handshakes -> WADDR (WREADY=0).
- Both handshake in the same cycle -> WRESP.
- WADDR/WDATA -> WRESP when the missing half handshakes.
REQ-013 SHALL perform the memory write on the clock edge of entry to WRESP; BVALID=1 from the next cycle (one-cycle latency after the last of AW/W).
REQ-014 SHALL hold BVALID and BRESP stable until BREADY=1, then return to IDLE; AWREADY and WREADY stay 0 while in WRESP.
REQ-015 SHALL write only the bytes whose WSTRB bit is 1; WSTRB=0 still completes with OKAY and modifies nothing.
REQ-016 SHALL use read FSM states IDLE, RDATA.
- IDLE: ARREADY=1; an AR handshake -> RDATA.
- RDATA: RVALID=1 from the cycle after the AR handshake; RDATA/RRESP held stable until RREADY=1, then -> IDLE.
REQ-017 SHALL return pre-write data when a read is accepted in the same cycle the write commits to the same word (read-before-write).
REQ-018 SHALL compute word index = (addr - BASE_ADDR) >> log2(STRB_WIDTH); address bits below the word boundary are ignored for data selection.
REQ-019 SHALL ignore VALID inputs while the corresponding READY is 0; a VALID that stays asserted is accepted when READY rises.
REQ-020 SHALL return RDATA=0 whenever RRESP is not OKAY.

Reset
REQ-021 SHALL, while ARESETN=0: force both FSMs to IDLE; drive AWREADY, WREADY, ARREADY, BVALID, RVALID to 0; drive BRESP, RRESP, RDATA to 0.
REQ-022 SHALL assert AWREADY, WREADY, ARREADY in the first cycle after ARESETN deasserts.
REQ-023 SHALL abandon any transaction in progress when reset asserts mid-operation, with no response issued; memory contents are not reset and are undefined after power-up.

Configuration
REQ-024 SHALL, with AXI_LITE_ERR_CHECK_EN defined:
- address outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) -> response RESP_DECERR, no memory access;
- in-range address not aligned to STRB_WIDTH -> RESP_SLVERR, no memory access;
- DECERR takes priority over SLVERR.
REQ-025 SHALL, without AXI_LITE_ERR_CHECK_EN: wrap the address modulo MEM_BYTES, ignore misalignment, and always respond RESP_OKAY.

Structure
REQ-026 SHALL place the following in axi_lite_pkg:
- write-FSM and read-FSM state enums;
- RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR constants;
- a function returning log2(STRB_WIDTH).
REQ-027 SHALL instantiate one sub-module, axi_lite_be_ram: byte-enable, single-write-port, synchronous-write, asynchronous-read RAM parameterised by DATA_WIDTH and depth.

Verification (DATA_WIDTH=32, MEM_BYTES=4096, BASE_ADDR=0)
REQ-028 SHALL cover: AW 0x10 and W 0xDEADBEEF with WSTRB=0xF in the same cycle, then AR 0x10 -> BRESP=OKAY one cycle later, RDATA=0xDEADBEEF.
REQ-029 SHALL cover: W 0x11223344 with WSTRB=0x5 sent two cycles before AW 0x10, over prior contents 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-030 SHALL cover: BREADY held 0 for 5 cycles -> BVALID=1 and BRESP stable throughout, AWREADY=0 throughout; accepted on the cycle BREADY rises.
REQ-031 SHALL cover, with AXI_LITE_ERR_CHECK_EN: AR 0x1000 -> RRESP=DECERR, RDATA=0; AW 0x12 -> BRESP=SLVERR, memory unchanged.
REQ-032 SHALL cover: ARESETN pulsed low while in WDATA -> no BVALID; all READYs=1 one cycle after release.
REQ-033 SHALL cover: read and write to 0x20 committing in the same cycle, prior contents 0x0 -> read returns 0x0, next read returns the written data.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types, response codes and helpers for the AXI4-Lite memory slave.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WADDR,
    W_WDATA,
    W_WRESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RDATA
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Byte-offset bits inside one data word, i.e. log2 of the strobe width.
  function automatic int strbLog2(input int strbWidth);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) < strbWidth) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/axi_lite_be_ram.sv
// Byte-enable RAM: one synchronous write port, one asynchronous read port, no reset.
module axi_lite_be_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_wrIdx,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic [STRB_WIDTH-1:0] i_wrStrb,
  input  logic [IDX_W-1:0]      i_rdIdx,
  output logic [DATA_WIDTH-1:0] o_rdData
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (i_wrStrb[i]) r_mem[i_wrIdx][8*i +: 8] <= i_wrData[8*i +: 8];
      end
    end
  end

  assign o_rdData = r_mem[i_rdIdx];

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory slave with independent write and read FSMs over a byte-enable RAM.
// Define AXI_LITE_ERR_CHECK_EN for DECERR/SLVERR checking; otherwise addresses wrap and always respond OKAY.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_BYTES  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  localparam int                   STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int OFFS      = strbLog2(STRB_WIDTH);
  localparam int DEPTH     = MEM_BYTES / STRB_WIDTH;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RAM_DEPTH = 1 << IDX_W;

  wr_state_e             r_wrState;
  rd_state_e             r_rdState;
  logic                  r_awReady, r_wReady, r_bValid, r_arReady, r_rValid;
  logic [1:0]            r_bResp, r_rResp;
  logic [DATA_WIDTH-1:0] r_rData;
  logic [ADDR_WIDTH-1:0] r_awAddr;
  logic [DATA_WIDTH-1:0] r_wData;
  logic [STRB_WIDTH-1:0] r_wStrb;

  logic                  w_awHs, w_wHs, w_arHs, w_wrCommit, w_ramWe;
  logic [ADDR_WIDTH-1:0] w_wrAddr, w_wrOff, w_rdOff;
  logic [DATA_WIDTH-1:0] w_wrData, w_ramRdData;
  logic [STRB_WIDTH-1:0] w_wrStrb;
  logic [IDX_W-1:0]      w_wrIdx, w_rdIdx;
  logic [1:0]            w_wrResp, w_rdResp;
  logic                  w_unused;

  assign w_awHs = AWVALID && r_awReady;
  assign w_wHs  = WVALID && r_wReady;
  assign w_arHs = ARVALID && r_arReady;

  // The last half to arrive is taken live so the RAM write lands on the edge of entry to WRESP.
  assign w_wrAddr = w_awHs ? AWADDR : r_awAddr;
  assign w_wrData = w_wHs ? WDATA : r_wData;
  assign w_wrStrb = w_wHs ? WSTRB : r_wStrb;

  assign w_wrCommit = ((r_wrState == W_IDLE)  && w_awHs && w_wHs) ||
                      ((r_wrState == W_WADDR) && w_awHs) ||
                      ((r_wrState == W_WDATA) && w_wHs);

  assign w_wrOff = w_wrAddr - BASE_ADDR;
  assign w_rdOff = ARADDR - BASE_ADDR;
  assign w_wrIdx = w_wrOff[OFFS +: IDX_W];
  assign w_rdIdx = w_rdOff[OFFS +: IDX_W];
  assign w_unused = &{1'b0, w_wrOff, w_rdOff};

`ifdef AXI_LITE_ERR_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

  function automatic logic [1:0] addrResp(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] a, lo, hi;
    a  = {1'b0, addr};
    lo = {1'b0, BASE_ADDR};
    hi = lo + (ADDR_WIDTH + 1)'(MEM_BYTES);
    if ((a < lo) || (a >= hi)) return RESP_DECERR;
    if ((addr & ALIGN_MASK) != '0) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  assign w_wrResp = addrResp(w_wrAddr);
  assign w_rdResp = addrResp(ARADDR);
`else
  assign w_wrResp = RESP_OKAY;
  assign w_rdResp = RESP_OKAY;
`endif

  assign w_ramWe = w_wrCommit && (w_wrResp == RESP_OKAY);

  axi_lite_be_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (RAM_DEPTH)
  ) u_ram (
    .i_clk   (ACLK),
    .i_we    (w_ramWe),
    .i_wrIdx (w_wrIdx),
    .i_wrData(w_wrData),
    .i_wrStrb(w_wrStrb),
    .i_rdIdx (w_rdIdx),
    .o_rdData(w_ramRdData)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wrState <= W_IDLE;
      r_awReady <= 1'b0;
      r_wReady  <= 1'b0;
      r_bValid  <= 1'b0;
      r_bResp   <= RESP_OKAY;
      r_awAddr  <= '0;
      r_wData   <= '0;
      r_wStrb   <= '0;
    end else begin
      case (r_wrState)
        W_IDLE: begin
          r_awReady <= 1'b1;
          r_wReady  <= 1'b1;
          if (w_awHs) r_awAddr <= AWADDR;
          if (w_wHs) begin
            r_wData <= WDATA;
            r_wStrb <= WSTRB;
          end
          if (w_wrCommit) begin
            r_wrState <= W_WRESP;
            r_awReady <= 1'b0;
            r_wReady  <= 1'b0;
            r_bValid  <= 1'b1;
            r_bResp   <= w_wrResp;
          end else if (w_awHs) begin
            r_wrState <= W_WDATA;
            r_awReady <= 1'b0;
          end else if (w_wHs) begin
            r_wrState <= W_WADDR;
            r_wReady  <= 1'b0;
          end
        end
        W_WADDR, W_WDATA: begin
          if (w_wrCommit) begin
            r_wrState <= W_WRESP;
            r_awReady <= 1'b0;
            r_wReady  <= 1'b0;
            r_bValid  <= 1'b1;
            r_bResp   <= w_wrResp;
          end
        end
        W_WRESP: begin
          if (BREADY) begin
            r_wrState <= W_IDLE;
            r_bValid  <= 1'b0;
            r_bResp   <= RESP_OKAY;
            r_awReady <= 1'b1;
            r_wReady  <= 1'b1;
          end
        end
        default: r_wrState <= W_IDLE;
      endcase
    end
  end

  // RAM read is asynchronous, so a read accepted on a write-commit edge sees pre-write data.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rdState <= R_IDLE;
      r_arReady <= 1'b0;
      r_rValid  <= 1'b0;
      r_rResp   <= RESP_OKAY;
      r_rData   <= '0;
    end else begin
      case (r_rdState)
        R_IDLE: begin
          r_arReady <= 1'b1;
          if (w_arHs) begin
            r_rdState <= R_RDATA;
            r_arReady <= 1'b0;
            r_rValid  <= 1'b1;
            r_rResp   <= w_rdResp;
            r_rData   <= (w_rdResp == RESP_OKAY) ? w_ramRdData : '0;
          end
        end
        R_RDATA: begin
          if (RREADY) begin
            r_rdState <= R_IDLE;
            r_arReady <= 1'b1;
            r_rValid  <= 1'b0;
            r_rResp   <= RESP_OKAY;
            r_rData   <= '0;
          end
        end
        default: r_rdState <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = r_awReady;
  assign WREADY  = r_wReady;
  assign BVALID  = r_bValid;
  assign BRESP   = r_bResp;
  assign ARREADY = r_arReady;
  assign RVALID  = r_rValid;
  assign RRESP   = r_rResp;
  assign RDATA   = r_rData;

endmodule
